// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla sequencer.
//  - INSTR_W and instruction field positions:
//    [16:13] RAM dir, [12:9] OP, [8:5] dir1, [4:1] dir2, [0] En (RAM write enable).
//  - estado_t: sequencer state encoding.
//  - sin_escritura(): instruction with its write enable cleared.
package jericalla_pkg;

    localparam int unsigned INSTR_W    = 17;
    localparam int unsigned DIR_RAM_HI = 16;
    localparam int unsigned DIR_RAM_LO = 13;
    localparam int unsigned OP_HI      = 12;
    localparam int unsigned OP_LO      = 9;
    localparam int unsigned DIR1_HI    = 8;
    localparam int unsigned DIR1_LO    = 5;
    localparam int unsigned DIR2_HI    = 4;
    localparam int unsigned DIR2_LO    = 1;
    localparam int unsigned EN_BIT     = 0;

    typedef enum logic [2:0] {
        StIdle,
        StCarga,
        StEjec,
        StEscr,
        StEspera
    } estado_t;

    // Reassemble the fields, then drop the write enable so the datapath sees the
    // operands without committing a RAM write.
    function automatic logic [INSTR_W-1:0] sin_escritura(input logic [INSTR_W-1:0] instr);
        logic [INSTR_W-1:0] o;
        o = {instr[DIR_RAM_HI:DIR_RAM_LO], instr[OP_HI:OP_LO], instr[DIR1_HI:DIR1_LO],
             instr[DIR2_HI:DIR2_LO], instr[EN_BIT]};
        o[EN_BIT] = 1'b0;
        return o;
    endfunction

endpackage

// File: rtl/jericalla_fifo.sv
// Instruction FIFO for the Jericalla sequencer.
//  clk, rst_n : clock, asynchronous active-low reset (clears pointers)
//  push, din  : write din when push (caller guarantees !full)
//  pop        : advance the head (ignored when empty)
//  full, empty: occupancy flags
//  dout       : current head word; a pop in the same cycle still sees the old head
module jericalla_fifo #(
    parameter int unsigned PROF  = 8,
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = $clog2(PROF);

    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [PROF];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        dout  = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/jericalla_secuenciador.sv
// Sequencer for the Jericalla ROM/ALU/RAM datapath. Buffers host instructions in a FIFO
// and issues each one in a 3-cycle load/execute/write cycle; the RAM write enable
// (instr_out[0]) is a clean one-cycle pulse in the write phase only.
// Optional feature macro JERICALLA_PASO_EN: adds input paso and a wait state between
// instructions that is left only on a paso pulse (single-step mode).
//  clk, rst_n          : clock, asynchronous active-low reset
//  in_instr, in_valid  : host push; accepted when in_valid && in_ready
//  in_ready            : FIFO not full
//  inicio, abortar     : start a run / stop the current run
//  paso                : single-step advance (JERICALLA_PASO_EN only)
//  instr_out           : instruction to the datapath, bit 0 = gated RAM write enable
//  zf_in               : datapath zero flag
//  ocupado, fin        : busy flag / one-cycle end-of-run pulse
//  zf_ultimo           : ZF captured in the execute phase of the last instruction
//  cnt_ejec, cnt_zf    : completed instructions / completed ones with ZF set
module jericalla_secuenciador
    import jericalla_pkg::*;
#(
    parameter int unsigned PROF  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               inicio,
    input  logic               abortar,
`ifdef JERICALLA_PASO_EN
    input  logic               paso,
`endif
    output logic [INSTR_W-1:0] instr_out,
    input  logic               zf_in,
    output logic               ocupado,
    output logic               fin,
    output logic               zf_ultimo,
    output logic [CNT_W-1:0]   cnt_ejec,
    output logic [CNT_W-1:0]   cnt_zf
);

    estado_t            estado;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] cabeza;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               hay_dato;

    assign in_ready = !full;
    assign push     = in_valid && !full;
    // A word arriving in the deciding cycle already counts, so it joins the current run.
    assign hay_dato = !empty || push;
    // An abort in the load phase leaves the head word in the FIFO.
    assign pop      = (estado == StCarga) && !abortar;
    assign ocupado  = (estado != StIdle);

    jericalla_fifo #(
        .PROF  (PROF),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_instr),
        .full  (full),
        .empty (empty),
        .dout  (cabeza)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= StIdle;
            ir        <= '0;
            instr_out <= '0;
            fin       <= 1'b0;
            zf_ultimo <= 1'b0;
            cnt_ejec  <= '0;
            cnt_zf    <= '0;
        end else begin
            fin       <= 1'b0;
            instr_out <= '0;
            unique case (estado)
                StIdle: begin
                    if (inicio) begin
                        if (hay_dato) begin
                            estado <= StCarga;
                        end else begin
                            fin <= 1'b1;
                        end
                    end
                end
                StCarga: begin
                    if (abortar) begin
                        estado <= StIdle;
                        fin    <= 1'b1;
                    end else begin
                        ir        <= cabeza;
                        instr_out <= sin_escritura(cabeza);
                        estado    <= StEjec;
                    end
                end
                StEjec: begin
                    if (abortar) begin
                        estado <= StIdle;
                        fin    <= 1'b1;
                    end else begin
                        zf_ultimo <= zf_in;
                        instr_out <= ir;
                        estado    <= StEscr;
                    end
                end
                StEscr: begin
                    cnt_ejec <= cnt_ejec + 1'b1;
                    cnt_zf   <= cnt_zf + {{(CNT_W-1){1'b0}}, zf_ultimo};
                    if (abortar || !hay_dato) begin
                        estado <= StIdle;
                        fin    <= 1'b1;
                    end else begin
`ifdef JERICALLA_PASO_EN
                        estado <= StEspera;
`else
                        estado <= StCarga;
`endif
                    end
                end
`ifdef JERICALLA_PASO_EN
                StEspera: begin
                    if (abortar) begin
                        estado <= StIdle;
                        fin    <= 1'b1;
                    end else if (paso) begin
                        estado <= StCarga;
                    end
                end
`endif
                default: estado <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jericalla_secuenciador.sv
module tb_jericalla_secuenciador;

    localparam int unsigned PROF  = 8;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        logic [16:0] instr;
        int unsigned cyc;
    } wr_t;

    typedef struct {
        int unsigned cyc;
        logic [15:0] ce;
        logic [15:0] cz;
        logic        zl;
    } fin_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic        inicio;
    logic        abortar;
    logic        paso;
    logic [16:0] instr_out;
    logic        zf_in;
    logic        ocupado;
    logic        fin;
    logic        zf_ultimo;
    logic [15:0] cnt_ejec;
    logic [15:0] cnt_zf;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    // Reference model state
    logic [16:0] model_q[$];
    bit          zf_plan[$];
    wr_t         exp_wr[$];
    fin_t        exp_fin[$];
    logic [15:0] m_ce = '0;
    logic [15:0] m_cz = '0;
    logic        m_zl = 1'b0;
    int          run_pushes;

    jericalla_secuenciador #(
        .PROF  (PROF),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_instr  (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inicio    (inicio),
        .abortar   (abortar),
`ifdef JERICALLA_PASO_EN
        .paso      (paso),
`endif
        .instr_out (instr_out),
        .zf_in     (zf_in),
        .ocupado   (ocupado),
        .fin       (fin),
        .zf_ultimo (zf_ultimo),
        .cnt_ejec  (cnt_ejec),
        .cnt_zf    (cnt_zf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write pulse or fin.
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_out[0]) begin
                chk("wr_pending", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_instr", instr_out, e.instr);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (fin) begin
                chk("fin_pending", exp_fin.size() != 0, 1);
                if (exp_fin.size() != 0) begin
                    fin_t f;
                    f = exp_fin.pop_front();
                    chk("fin_cycle", cyc, f.cyc);
                    chk("fin_cnt_ejec", cnt_ejec, f.ce);
                    chk("fin_cnt_zf", cnt_zf, f.cz);
                    chk("fin_zf_ultimo", zf_ultimo, f.zl);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inicio   = 1'b0;
        abortar  = 1'b0;
        paso     = 1'b0;
        zf_in    = 1'($urandom);
    endtask

    task automatic maybe_push(input int pct);
        logic [31:0] r;
        if ($urandom_range(0, 99) < pct) begin
            r        = $urandom;
            in_valid = 1'b1;
            in_instr = r[16:0];
            run_pushes++;
            if (model_q.size() < PROF) model_q.push_back(r[16:0]);
        end
    endtask

    task automatic push_word(input logic [16:0] w);
        chk("in_ready", in_ready, model_q.size() < PROF);
        in_valid = 1'b1;
        in_instr = w;
        if (model_q.size() < PROF) model_q.push_back(w);
        step();
    endtask

    task automatic idle_cycle(input int pct);
        chk("ocupado_idle", ocupado, 0);
        chk("instr_out_idle", instr_out, 0);
        chk("in_ready", in_ready, model_q.size() < PROF);
        maybe_push(pct);
        step();
    endtask

    task automatic expect_fin();
        fin_t f;
        f.cyc = cyc + 1;
        f.ce  = m_ce;
        f.cz  = m_cz;
        f.zl  = m_zl;
        exp_fin.push_back(f);
    endtask

    // Checks common to every busy cycle, then optional push and ignored inicio.
    task automatic busy_cycle(input int pct);
        chk("ocupado_busy", ocupado, 1);
        chk("in_ready", in_ready, model_q.size() < PROF);
        maybe_push(run_pushes < 6 ? pct : 0);
        if ($urandom_range(0, 3) == 0) inicio = 1'b1;
    endtask

    // One run: each instruction is load, execute, write; the run continues while a
    // word is available by the end of a write phase. abort_ph 1 = execute, 2 = write.
    task automatic run(input int abort_k, input int abort_ph, input int pct);
        logic [16:0] cur;
        logic [16:0] ex;
        logic        z;
        int          k;
        chk("ocupado_idle", ocupado, 0);
        chk("in_ready", in_ready, model_q.size() < PROF);
        run_pushes = 0;
        inicio = 1'b1;
        maybe_push(pct);
        if (model_q.size() == 0) begin
            expect_fin();
            step();
            return;
        end
        step();
        k = 0;
        forever begin
            busy_cycle(pct);
            chk("instr_out_carga", instr_out, 0);
            cur = model_q.pop_front();
            step();

            busy_cycle(pct);
            ex = cur;
            ex[0] = 1'b0;
            chk("instr_out_ejec", instr_out, ex);
            z = (zf_plan.size() != 0) ? zf_plan.pop_front() : 1'($urandom);
            zf_in = z;
            if (abort_k == k && abort_ph == 1) begin
                abortar = 1'b1;
                expect_fin();
                step();
                return;
            end
            step();

            busy_cycle(pct);
            chk("instr_out_escr", instr_out, cur);
            chk("zf_ultimo", zf_ultimo, z);
            if (cur[0]) begin
                wr_t e;
                e.instr = cur;
                e.cyc   = cyc;
                exp_wr.push_back(e);
            end
            m_ce = m_ce + 1;
            m_cz = m_cz + 16'(z);
            m_zl = z;
            if (abort_k == k && abort_ph == 2) abortar = 1'b1;
            if (abortar || model_q.size() == 0) begin
                expect_fin();
                step();
                return;
            end
            step();
            k++;
`ifdef JERICALLA_PASO_EN
            repeat ($urandom_range(0, 3)) begin
                busy_cycle(pct);
                chk("instr_out_espera", instr_out, 0);
                step();
            end
            busy_cycle(pct);
            paso = 1'b1;
            step();
`endif
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_instr = '0;
        in_valid = 1'b0;
        inicio   = 1'b0;
        abortar  = 1'b0;
        paso     = 1'b0;
        zf_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr_out", instr_out, 0);
        chk("rst_fin", fin, 0);
        chk("rst_zf_ultimo", zf_ultimo, 0);
        chk("rst_cnt_ejec", cnt_ejec, 0);
        chk("rst_cnt_zf", cnt_zf, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a write phase removes the write at once.
        in_valid = 1'b1;
        in_instr = 17'h1_2345;
        step();
        inicio = 1'b1;
        step();
        step();
        step();
        chk("mid_escr_instr_out", instr_out, 17'h1_2345);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_instr_out", instr_out, 0);
        chk("mid_rst_cnt_ejec", cnt_ejec, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_ocupado", ocupado, 0);
        #1;
        rst_n = 1'b1;
        step();
        idle_cycle(0);

        // Three instructions, En = 1,0,1: writes at cycles 3 and 9, fin at 10.
        push_word(17'h0_a4c3);
        push_word(17'h1_5b12);
        push_word(17'h0_3c7f);
        run(-1, 0, 0);
        idle_cycle(0);
        chk("three_cnt_ejec", cnt_ejec, 3);

        // Fill the FIFO; in_ready drops and returns after the first pop.
        for (int i = 0; i < 9; i++) push_word(17'(i * 4099 + 1));
        idle_cycle(0);
        run(-1, 0, 0);
        idle_cycle(0);

        // ZF only on the second of four instructions.
        zf_plan = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) push_word(17'(i * 777 + 3));
        run(-1, 0, 0);
        idle_cycle(0);

        // Abort in execute of the first instruction, then resume.
        for (int i = 0; i < 3; i++) push_word(17'(i * 1234 + 1));
        run(0, 1, 0);
        idle_cycle(0);
        chk("abort_fifo_kept", model_q.size(), 2);
        run(-1, 0, 0);
        idle_cycle(0);

        // Abort in the write phase: the write completes.
        for (int i = 0; i < 2; i++) push_word(17'(i * 99 + 1));
        run(0, 2, 0);
        idle_cycle(0);
        run(-1, 0, 0);
        idle_cycle(0);

        // Start with an empty FIFO.
        run(-1, 0, 0);
        idle_cycle(0);
        idle_cycle(0);

        // Randomized runs with pushes during execution and occasional aborts.
        repeat (30) begin
            int r;
            repeat ($urandom_range(1, 6)) idle_cycle(60);
            r = $urandom_range(0, 9);
            if (r == 0) run($urandom_range(0, 2), 1, $urandom_range(0, 40));
            else if (r == 1) run($urandom_range(0, 2), 2, $urandom_range(0, 40));
            else run(-1, 0, $urandom_range(0, 40));
            idle_cycle(0);
        end

        idle_cycle(0);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("fin_queue_drained", exp_fin.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
